// File: rtl/apb_ram_param.sv
// apb_ram_param: parametrised APB slave RAM with wait states, out-of-range error and abort handling
// optional byte-lane write strobes enabled by defining APB_RAM_STRB_EN
module apb_ram_param #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              wr_en,
  input  logic              psel,
  input  logic              pen,
  input  logic [DATA_W-1:0] pwdata,
`ifdef APB_RAM_STRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pselverr
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IW-1:0]     r_idx;
  logic              r_wr;
  logic              r_oor;
  logic [3:0]        r_cnt;
  logic              w_oor;
  logic              w_setup;
  logic              w_done;
  logic [IW-1:0]     w_idx;
  assign w_oor   = {1'b0, paddr} >= LIM;
  assign w_idx   = w_oor ? '0 : paddr[IW-1:0];
  assign w_setup = r_state == IDLE && psel && !pen;
  assign w_done  = r_state == ACCESS && psel && pen && pready;
  // memory is deliberately not reset; a reset edge suppresses any pending commit
  always_ff @(posedge clk)
    if (!rst && w_done && r_wr && !r_oor)
`ifdef APB_RAM_STRB_EN
      for (int b = 0; b < DATA_W/8; b++)
        if (pstrb[b]) r_mem[r_idx][8*b +: 8] <= pwdata[8*b +: 8];
`else
      r_mem[r_idx] <= pwdata;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_wr     <= 1'b0;
      r_oor    <= 1'b0;
      prdata   <= '0;
      pready   <= 1'b0;
      pselverr <= 1'b0;
    end else if (w_setup) begin
      r_state  <= ACCESS;
      r_idx    <= w_idx;
      r_wr     <= wr_en;
      r_oor    <= w_oor;
      r_cnt    <= WS;
      prdata   <= (!wr_en && !w_oor) ? r_mem[w_idx] : '0;
      pready   <= WS == 4'd0;
      pselverr <= WS == 4'd0 && w_oor;
    end else if (r_state == ACCESS) begin
      if (!psel || w_done) begin
        r_state  <= IDLE;
        r_cnt    <= '0;
        pready   <= 1'b0;
        pselverr <= 1'b0;
      end else if (pen && r_cnt != 4'd0) begin
        r_cnt    <= r_cnt - 4'd1;
        pready   <= r_cnt == 4'd1;
        pselverr <= r_cnt == 4'd1 && r_oor;
      end
    end
endmodule

// File: tb/tb_apb_ram_param.sv
// tb_apb_ram_param: directed checks on three instances (default, DEPTH=200/WS=2, WS=3)
module tb_apb_ram_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  paddr = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  psel = '0;
  logic        pen = 1'b0;
  logic [31:0] pwdata = '0;
`ifdef APB_RAM_STRB_EN
  logic [3:0]  pstrb = 4'hF;
`endif
  logic [31:0] prd [3];
  logic [2:0]  prdy;
  logic [2:0]  perr;
  int pass = 0;
  int total = 0;
  always #5 clk = ~clk;
  apb_ram_param u0 (
    .clk(clk), .rst(rst), .paddr(paddr), .wr_en(wr_en), .psel(psel[0]), .pen(pen), .pwdata(pwdata),
`ifdef APB_RAM_STRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prd[0]), .pready(prdy[0]), .pselverr(perr[0]));
  apb_ram_param #(.DEPTH(200), .WAIT_STATES(2)) u1 (
    .clk(clk), .rst(rst), .paddr(paddr), .wr_en(wr_en), .psel(psel[1]), .pen(pen), .pwdata(pwdata),
`ifdef APB_RAM_STRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prd[1]), .pready(prdy[1]), .pselverr(perr[1]));
  apb_ram_param #(.WAIT_STATES(3)) u2 (
    .clk(clk), .rst(rst), .paddr(paddr), .wr_en(wr_en), .psel(psel[2]), .pen(pen), .pwdata(pwdata),
`ifdef APB_RAM_STRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prd[2]), .pready(prdy[2]), .pselverr(perr[2]));
  // called at a negedge; returns at the negedge right after the completion edge
  task automatic xfer(input int d, input logic w, input logic [7:0] a, input logic [31:0] wd,
                      input logic scr, output logic [31:0] rd, output logic er, output int len);
    paddr = a; wr_en = w; pwdata = wd; psel = '0; psel[d] = 1'b1; pen = 1'b0;
    len = 0; rd = '0; er = 1'b0;
    @(negedge clk);
    pen = 1'b1;
    for (int i = 0; i < 40; i++) begin
      len++;
      if (prdy[d]) begin
        rd = prd[d]; er = perr[d]; pwdata = wd;
        break;
      end
      if (scr) begin
        paddr = ~a; wr_en = ~w; pwdata = ~wd;
      end
      @(negedge clk);
    end
    if (!prdy[d]) begin
      total++;
      $display("FAIL xfer_timeout dut%0d addr %h: pready never rose", d, a);
    end
    @(negedge clk);
    psel = '0; pen = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; psel = '0; pen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      total++;
      if ({prd[d], prdy[d], perr[d]} !== 34'd0) $display("FAIL reset dut%0d: got %h/%b/%b want 0/0/0", d, prd[d], prdy[d], perr[d]);
      else pass++;
    end
  endtask
  task automatic test_basic();
    logic [31:0] rd; logic er; int len;
    xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, rd, er, len);
    total++; if ({er, len} !== {1'b0, 32'd1}) $display("FAIL basic_wr: got err %b len %0d want 0 1", er, len); else pass++;
    xfer(0, 1'b1, 8'hFF, 32'hA5A50F0F, 1'b0, rd, er, len);
    xfer(0, 0, 8'h10, 32'h0, 1'b0, rd, er, len);
    total++; if ({rd, er, len} !== {32'hDEADBEEF, 1'b0, 32'd1}) $display("FAIL basic_rd: got %h err %b len %0d want deadbeef 0 1", rd, er, len); else pass++;
    total++; if ({prdy[0], prd[0]} !== {1'b0, 32'hDEADBEEF}) $display("FAIL basic_hold: got pready %b prdata %h want 0 deadbeef", prdy[0], prd[0]); else pass++;
    xfer(0, 0, 8'hFF, 32'h0, 1'b0, rd, er, len);
    total++; if ({rd, er} !== {32'hA5A50F0F, 1'b0}) $display("FAIL basic_top: got %h err %b want a5a50f0f 0", rd, er); else pass++;
  endtask
  task automatic test_oor();
    logic [31:0] rd; logic er; int len;
    xfer(1, 1'b1, 8'h00, 32'h11112222, 1'b0, rd, er, len);
    xfer(1, 1'b1, 8'hC7, 32'hC7C7C7C7, 1'b0, rd, er, len);
    total++; if ({er, len} !== {1'b0, 32'd3}) $display("FAIL oor_last_wr: got err %b len %0d want 0 3", er, len); else pass++;
    xfer(1, 1'b1, 8'hC8, 32'hCAFEF00D, 1'b0, rd, er, len);
    total++; if ({er, len} !== {1'b1, 32'd3}) $display("FAIL oor_wr: got err %b len %0d want 1 3", er, len); else pass++;
    xfer(1, 0, 8'hC7, 32'h0, 1'b0, rd, er, len);
    total++; if ({rd, er} !== {32'hC7C7C7C7, 1'b0}) $display("FAIL oor_last_rd: got %h err %b want c7c7c7c7 0", rd, er); else pass++;
    xfer(1, 0, 8'hC8, 32'h0, 1'b0, rd, er, len);
    total++; if ({rd, er} !== {32'h0, 1'b1}) $display("FAIL oor_rd: got %h err %b want 0 1", rd, er); else pass++;
    total++; if (perr[1] !== 1'b0) $display("FAIL oor_err_clear: got %b want 0", perr[1]); else pass++;
    xfer(1, 0, 8'h00, 32'h0, 1'b0, rd, er, len);
    total++; if ({rd, er} !== {32'h11112222, 1'b0}) $display("FAIL oor_alias: got %h err %b want 11112222 0", rd, er); else pass++;
  endtask
  task automatic test_wait();
    logic [31:0] rd; logic er; int len;
    xfer(2, 1'b1, 8'hFA, 32'h12345678, 1'b0, rd, er, len);
    xfer(2, 1'b1, 8'h05, 32'h0BADCAFE, 1'b1, rd, er, len);
    total++; if ({er, len} !== {1'b0, 32'd4}) $display("FAIL wait_wr: got err %b len %0d want 0 4", er, len); else pass++;
    xfer(2, 0, 8'h05, 32'h0, 1'b0, rd, er, len);
    total++; if ({rd, len} !== {32'h0BADCAFE, 32'd4}) $display("FAIL wait_rd: got %h len %0d want 0badcafe 4", rd, len); else pass++;
    xfer(2, 0, 8'hFA, 32'h0, 1'b0, rd, er, len);
    total++; if (rd !== 32'h12345678) $display("FAIL wait_latch: got %h want 12345678", rd); else pass++;
  endtask
  task automatic test_abort();
    logic [31:0] rd; logic er; int len;
    xfer(1, 1'b1, 8'h20, 32'h5555AAAA, 1'b0, rd, er, len);
    paddr = 8'h20; wr_en = 1'b1; pwdata = 32'h1234; psel = 3'b010; pen = 1'b0;
    @(negedge clk); pen = 1'b1;
    @(negedge clk); psel = '0; pen = 1'b0;
    @(negedge clk);
    total++; if ({prdy[1], perr[1]} !== 2'b00) $display("FAIL abort_out: got %b%b want 00", prdy[1], perr[1]); else pass++;
    xfer(1, 0, 8'h20, 32'h0, 1'b0, rd, er, len);
    total++; if ({rd, len} !== {32'h5555AAAA, 32'd3}) $display("FAIL abort_rd: got %h len %0d want 5555aaaa 3", rd, len); else pass++;
  endtask
  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int len;
    xfer(2, 1'b1, 8'h06, 32'h77777777, 1'b0, rd, er, len);
    paddr = 8'h06; wr_en = 1'b1; pwdata = 32'h99999999; psel = 3'b100; pen = 1'b0;
    @(negedge clk); pen = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; psel = '0; pen = 1'b0;
    total++; if ({prd[2], prdy[2], perr[2]} !== 34'd0) $display("FAIL rstmid_wr: got %h/%b/%b want 0/0/0", prd[2], prdy[2], perr[2]); else pass++;
    paddr = 8'h05; wr_en = 1'b0; psel = 3'b100; pen = 1'b0;
    @(negedge clk); pen = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({prd[2], prdy[2]} !== {32'h0BADCAFE, 1'b1}) $display("FAIL rstmid_pre: got %h/%b want 0badcafe/1", prd[2], prdy[2]); else pass++;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; psel = '0; pen = 1'b0;
    total++; if ({prd[2], prdy[2], perr[2]} !== 34'd0) $display("FAIL rstmid_rd: got %h/%b/%b want 0/0/0", prd[2], prdy[2], perr[2]); else pass++;
    xfer(2, 0, 8'h06, 32'h0, 1'b0, rd, er, len);
    total++; if (rd !== 32'h77777777) $display("FAIL rstmid_mem: got %h want 77777777", rd); else pass++;
  endtask
  task automatic test_idle_pen();
    logic [31:0] rd; logic er; int len;
    paddr = 8'h10; wr_en = 1'b0; psel = 3'b001; pen = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (prdy[0] !== 1'b0) $display("FAIL idle_pen: got pready %b want 0", prdy[0]); else pass++;
    psel = '0; pen = 1'b0;
    @(negedge clk);
    xfer(0, 0, 8'h10, 32'h0, 1'b0, rd, er, len);
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL idle_after: got %h want deadbeef", rd); else pass++;
  endtask
`ifdef APB_RAM_STRB_EN
  task automatic test_strb();
    logic [31:0] rd; logic er; int len;
    pstrb = 4'hF;
    xfer(0, 1'b1, 8'h03, 32'hFFFFFFFF, 1'b0, rd, er, len);
    pstrb = 4'b0101;
    xfer(0, 1'b1, 8'h03, 32'h00000000, 1'b0, rd, er, len);
    pstrb = 4'b0000;
    xfer(0, 1'b1, 8'h03, 32'h12345678, 1'b0, rd, er, len);
    total++; if ({er, len} !== {1'b0, 32'd1}) $display("FAIL strb_zero: got err %b len %0d want 0 1", er, len); else pass++;
    pstrb = 4'hF;
    xfer(0, 0, 8'h03, 32'h0, 1'b0, rd, er, len);
    total++; if (rd !== 32'hFF00FF00) $display("FAIL strb_rd: got %h want ff00ff00", rd); else pass++;
  endtask
`endif
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_oor();
    test_wait();
    test_abort();
    test_reset_mid();
    test_idle_pen();
`ifdef APB_RAM_STRB_EN
    test_strb();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
